conv_enc_pack: RTL and testbench
================================

// Module: conv_enc_pack
// PURPOSE
// - Transmit-side partner of the decoder's frame slicer: convolutional encoder (K=3) plus frame packer.
// - Accepts one info bit per handshake, encodes it at rate 1/2 or 1/3, and packs coded symbols MSB-first
//   into 16-bit frames.
// - The decoder slicer consumes these frames unchanged. Sits between the PS bit source and the channel/frame FIFO.
// PARAMETERS
// - FRAME_W  16  frame width in bits; fixed, not overridable.
// - K        3   constraint length; encoder state is K-1 = 2 bits.
// PORTS
// - clk            in   1   clock
// - rst            in   1   reset, asynchronous, active-low
// - en             in   1   block enable; when 0, all state holds and o_bit_ready=0
// - i_code_rate    in   1   `CODE_RATE_2 / `CODE_RATE_3, sampled at frame start only
// - i_bit          in   1   info bit
// - i_bit_valid    in   1   i_bit is valid
// - o_bit_ready    out  1   block accepts i_bit this cycle
// - i_flush        in   1   1-cycle pulse: terminate stream (tail + pad + last frame)
// - o_data_frame   out  16  packed coded frame
// - o_frame_valid  out  1   o_data_frame is valid; held until accepted
// - i_frame_ready  in   1   downstream accepts the frame
// - o_last         out  1   qualifies o_frame_valid: final frame of the stream
// BEHAVIOUR
// - Reset values: o_data_frame=0, o_frame_valid=0, o_last=0, o_bit_ready=0; encoder state s=00; slot=0; FSM=IDLE.
// - Encoder state: s[1] = previous bit, s[0] = bit before that. Coded bits per input bit b:
//   - c0 = b^s[1]^s[0]  (g=7)
//   - c1 = b^s[0]       (g=5)
//   - c2 = b^s[1]       (g=3, rate 1/3 only)
//   - After each bit: s <= {b, s[1]}.
// - Packing: slot n occupies bits 15-R*n downward, where R = 2 or 3. c0 is at the highest bit, then c1, then c2.
// - Frame capacity: rate 1/2 = 8 slots; rate 1/3 = 5 slots with bit0 = 0.
// - Rate latch: rate is captured when slot==0 and the first bit is accepted. Changes mid-frame are ignored.
// - FSM states:
//   - IDLE: o_bit_ready=0. Enters FILL when en=1.
//   - FILL: o_bit_ready=1 unless stalled. A bit is accepted on i_bit_valid & o_bit_ready.
//   - TAIL: injects two b=0 bits, one per cycle, without handshake; o_bit_ready=0. Returns s to 00.
//   - PAD: remaining slots are zero; the frame is closed with o_last=1, then the FSM goes to IDLE.
// - i_flush in FILL -> TAIL. i_flush in IDLE/TAIL/PAD is ignored.
// - If i_flush and an accepted bit occur in the same cycle, the bit is encoded first and the tail follows.
// - Tail bits that overflow the current frame continue into the next frame, and PAD applies to that frame.
// - If a frame fills exactly on the last tail bit, it is sent with o_last=1 and no extra frame is generated.
// - Double buffer: a pack register plus an output register.
//   - When the last slot is written, the completed frame moves to the output register on the next edge.
//   - The move happens if the output register is empty or drained in the same cycle (i_frame_ready & o_frame_valid).
//   - Otherwise o_bit_ready drops (stall) until the output is drained.
// - Latency: o_frame_valid rises 1 cycle after the handshake that fills the last slot. Throughput is 1 bit/cycle.
// - Output handshake: o_data_frame and o_last are stable while o_frame_valid=1 && i_frame_ready=0.
//   o_frame_valid clears on acceptance unless a new frame is loaded in the same cycle.
// - en=0 mid-operation: freezes everything, including TAIL progress. Frames already valid stay valid.
// - Reset mid-frame: the partial frame is discarded and state returns to reset values.
// STRUCTURE
// - Shared package param_def.sv holds `CODE_RATE_2, `CODE_RATE_3, and the generator constants G0=3'b111,
//   G1=3'b101, G2=3'b011.
// - Add an FSM state typedef {IDLE, FILL, TAIL, PAD} to the package.
// - One natural sub-module: conv_enc_core. Combinational coder (bit, state, rate) -> {c0,c1,c2} and next state.
//   It is shared with the encoder golden model in the bench.
// - Top level holds the FSM, slot counter, pack register, and output register.
// TESTING
// - Rate 1/2, bits 1,0,1,1,0,0,0,0 from reset, i_frame_ready=1 -> o_data_frame=16'hE170, o_last=0,
//   valid 1 cycle after the 8th bit.
// - Rate 1/3, bits 1,0,0,0,0 -> o_data_frame=16'hF700 (bit0=0), o_last=0.
// - Rate 1/2, bit 1 then i_flush -> single frame 16'hEC00 with o_last=1; FSM returns to IDLE with s=00.
// - Backpressure: i_frame_ready=0 with 16 bits streamed -> first frame held stable; o_bit_ready=0 after the 2nd
//   frame is full. Releasing i_frame_ready delivers both frames in order with no lost bits.
// - Rate change mid-frame (1/2 -> 1/3 after 3 bits) -> frame stays rate 1/2; the next frame uses 5-slot rate 1/3 packing.
// - Reset asserted mid-frame after 4 bits -> all outputs 0 immediately; the next 8 bits produce a clean frame
//   matching the golden model from s=00.

Source files
------------

// File: rtl/conv_enc_pack_pkg.sv
// Shared constants, types and packing helpers for the K=3 convolutional encoder and frame packer.
package conv_enc_pack_pkg;

    localparam int unsigned FRAME_W  = 16;
    localparam int unsigned K        = 3;
    localparam int unsigned ENC_W    = K - 1;
    localparam int unsigned CODE_W   = 3;
    localparam int unsigned SLOT_W   = 3;
    localparam int unsigned SHIFT_W  = $clog2(FRAME_W);
    localparam int unsigned SLOTS_R2 = 8;
    localparam int unsigned SLOTS_R3 = 5;

    localparam logic CODE_RATE_2 = 1'b0;
    localparam logic CODE_RATE_3 = 1'b1;

    // Tap vectors are ordered {oldest, previous, current} bit.
    localparam logic [K-1:0] G0 = 3'b111;
    localparam logic [K-1:0] G1 = 3'b101;
    localparam logic [K-1:0] G2 = 3'b011;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        TAIL,
        PAD
    } fsm_e;

    typedef struct packed {
        logic [FRAME_W-1:0] data;
        logic               last;
    } frame_t;

    // Bit offset from the frame MSB at which a slot starts.
    function automatic logic [SHIFT_W-1:0] slot_shift(input logic rate3, input logic [SLOT_W-1:0] slot);
        logic [SHIFT_W-1:0] s;
        s = SHIFT_W'(slot);
        return rate3 ? SHIFT_W'(s * SHIFT_W'(3)) : SHIFT_W'(s << 1);
    endfunction

    // Left-justified coded symbol moved down to its slot position.
    function automatic logic [FRAME_W-1:0] place_sym(input logic [CODE_W-1:0] sym, input logic [SHIFT_W-1:0] sh);
        return {sym, {(FRAME_W-CODE_W){1'b0}}} >> sh;
    endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Combinational K=3 coder: one info bit plus encoder state gives {c0,c1,c2} and the next state.
module conv_enc_core
    import conv_enc_pack_pkg::*;
(
    input  logic              bit_i,
    input  logic [ENC_W-1:0]  state_i,
    input  logic              rate3_i,
    output logic [CODE_W-1:0] code_c,
    output logic [ENC_W-1:0]  state_nxt_c
);

    logic [K-1:0] taps;

    always_comb begin
        taps        = {state_i[0], state_i[1], bit_i};
        code_c[2]   = ^(taps & G0);
        code_c[1]   = ^(taps & G1);
        code_c[0]   = rate3_i ? ^(taps & G2) : 1'b0;
        state_nxt_c = {bit_i, state_i[1]};
    end

endmodule

// File: rtl/conv_enc_pack.sv
// Convolutional encoder (K=3, rate 1/2 or 1/3) with MSB-first 16-bit frame packer.
// The pack register and the output register form a two-deep frame buffer.
module conv_enc_pack
    import conv_enc_pack_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               i_code_rate,
    input  logic               i_bit,
    input  logic               i_bit_valid,
    output logic               o_bit_ready,
    input  logic               i_flush,
    output logic [FRAME_W-1:0] o_data_frame,
    output logic               o_frame_valid,
    input  logic               i_frame_ready,
    output logic               o_last
);

    fsm_e               fsm_q, fsm_d;
    logic [ENC_W-1:0]   enc_s_q, enc_s_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic               rate_q, rate_d;
    frame_t             pack_q, pack_d;
    logic               pack_full_q, pack_full_d;
    logic               tail_cnt_q, tail_cnt_d;
    frame_t             out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               bit_ready_q, bit_ready_d;

    logic               out_drain;
    logic               out_free;
    logic               accept;
    logic               tail_wr;
    logic               wr_en;
    logic               wr_bit;
    logic               eff_rate3;
    logic               slot_last;
    logic [CODE_W-1:0]  code;
    logic [ENC_W-1:0]   s_next;
    logic [FRAME_W-1:0] pack_wr;
    logic               frame_done;
    frame_t             done_frame;

    conv_enc_core u_core (
        .bit_i       (wr_bit),
        .state_i     (enc_s_q),
        .rate3_i     (eff_rate3),
        .code_c      (code),
        .state_nxt_c (s_next)
    );

    // Write qualification and slot geometry for the current cycle.
    always_comb begin
        out_drain = out_valid_q & i_frame_ready;
        out_free  = ~out_valid_q | out_drain;
        accept    = en & bit_ready_q & i_bit_valid;
        tail_wr   = en & (fsm_q == TAIL) & ~pack_full_q;
        wr_en     = accept | tail_wr;
        wr_bit    = accept ? i_bit : 1'b0;
        // The first data bit of a frame uses the live rate; everything else the latched one.
        if ((fsm_q == FILL) && (slot_q == '0)) begin
            eff_rate3 = (i_code_rate == CODE_RATE_3);
        end else begin
            eff_rate3 = (rate_q == CODE_RATE_3);
        end
        slot_last = wr_en & (slot_q == (eff_rate3 ? SLOT_W'(SLOTS_R3 - 1) : SLOT_W'(SLOTS_R2 - 1)));
        pack_wr   = pack_q.data | place_sym(code, slot_shift(eff_rate3, slot_q));
    end

    // Next-state: FSM, encoder state, packing and the pack-to-output transfer.
    always_comb begin
        fsm_d       = fsm_q;
        enc_s_d     = enc_s_q;
        slot_d      = slot_q;
        rate_d      = rate_q;
        pack_d      = pack_q;
        pack_full_d = pack_full_q;
        tail_cnt_d  = tail_cnt_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        frame_done  = 1'b0;
        done_frame  = '0;

        if (out_drain) begin
            out_valid_d = 1'b0;
        end

        if (wr_en) begin
            enc_s_d     = s_next;
            pack_d.data = pack_wr;
            slot_d      = slot_q + SLOT_W'(1);
            if (accept && (slot_q == '0)) begin
                rate_d = i_code_rate;
            end
            if (slot_last) begin
                frame_done      = 1'b1;
                done_frame.data = pack_wr;
                done_frame.last = (fsm_q == TAIL) && tail_cnt_q;
            end
        end

        if (en) begin
            unique case (fsm_q)
                IDLE: fsm_d = FILL;
                FILL: begin
                    if (i_flush) begin
                        fsm_d      = TAIL;
                        tail_cnt_d = 1'b0;
                    end
                end
                TAIL: begin
                    if (tail_wr) begin
                        tail_cnt_d = 1'b1;
                        // A frame closed by the final tail bit is itself the last frame.
                        if (tail_cnt_q) begin
                            fsm_d = slot_last ? IDLE : PAD;
                        end
                    end
                end
                PAD: begin
                    if (!pack_full_q) begin
                        frame_done      = 1'b1;
                        done_frame.data = pack_q.data;
                        done_frame.last = 1'b1;
                        fsm_d           = IDLE;
                    end
                end
            endcase
        end

        if (frame_done) begin
            slot_d = '0;
            if (out_free) begin
                out_d       = done_frame;
                out_valid_d = 1'b1;
                pack_d      = '0;
            end else begin
                pack_d      = done_frame;
                pack_full_d = 1'b1;
            end
        end else if (en && pack_full_q && out_free) begin
            out_d       = pack_q;
            out_valid_d = 1'b1;
            pack_d      = '0;
            pack_full_d = 1'b0;
        end

        bit_ready_d = (fsm_d == FILL) & ~pack_full_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q       <= IDLE;
            enc_s_q     <= '0;
            slot_q      <= '0;
            rate_q      <= CODE_RATE_2;
            pack_q      <= '0;
            pack_full_q <= 1'b0;
            tail_cnt_q  <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            bit_ready_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            enc_s_q     <= enc_s_d;
            slot_q      <= slot_d;
            rate_q      <= rate_d;
            pack_q      <= pack_d;
            pack_full_q <= pack_full_d;
            tail_cnt_q  <= tail_cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            bit_ready_q <= bit_ready_d;
        end
    end

    // Enable gates the registered ready so a disable stops acceptance in the same cycle.
    assign o_bit_ready   = bit_ready_q & en;
    assign o_data_frame  = out_q.data;
    assign o_frame_valid = out_valid_q;
    assign o_last        = out_q.last;

endmodule

// File: tb/tb_conv_enc_pack.sv
// Scoreboard bench for conv_enc_pack: directed bit streams with hand-computed frames.
module tb_conv_enc_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        i_code_rate;
    logic        i_bit;
    logic        i_bit_valid;
    logic        o_bit_ready;
    logic        i_flush;
    logic [15:0] o_data_frame;
    logic        o_frame_valid;
    logic        i_frame_ready;
    logic        o_last;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic        hold_v = 1'b0;
    logic [15:0] hold_d = '0;
    logic        hold_l = 1'b0;

    always #5 clk = ~clk;

    conv_enc_pack dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .i_code_rate   (i_code_rate),
        .i_bit         (i_bit),
        .i_bit_valid   (i_bit_valid),
        .o_bit_ready   (o_bit_ready),
        .i_flush       (i_flush),
        .o_data_frame  (o_data_frame),
        .o_frame_valid (o_frame_valid),
        .i_frame_ready (i_frame_ready),
        .o_last        (o_last)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_frame(input logic [15:0] d, input logic l);
        exp_t e;
        e.d = d;
        e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic send_bit(input logic b);
        int n = 0;
        i_bit       = b;
        i_bit_valid = 1'b1;
        @(negedge clk);
        while (!o_bit_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bit_accept_timeout", 32'(o_bit_ready), 32'd1);
        @(posedge clk);
        #1;
        i_bit_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(bits[i]);
        end
    endtask

    task automatic pulse_flush();
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        @(negedge clk);
        while (!o_frame_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(o_frame_valid), 32'd1);
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output handshake pops one expected frame.
    always @(negedge clk) begin
        if (rst && o_frame_valid && i_frame_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL frame_unexpected: got data=%h last=%b, none expected", o_data_frame, o_last);
            end else begin
                mon_e = exp_q.pop_front();
                if (o_data_frame !== mon_e.d || o_last !== mon_e.l) begin
                    errors++;
                    $display("FAIL frame: got data=%h last=%b, expected data=%h last=%b",
                             o_data_frame, o_last, mon_e.d, mon_e.l);
                end
            end
        end
    end

    // Monitor: a stalled frame must stay valid and unchanged.
    always @(negedge clk) begin
        if (rst && hold_v) begin
            checks++;
            if (!o_frame_valid || o_data_frame !== hold_d || o_last !== hold_l) begin
                errors++;
                $display("FAIL hold_stable: got valid=%b data=%h last=%b, expected valid=1 data=%h last=%b",
                         o_frame_valid, o_data_frame, o_last, hold_d, hold_l);
            end
        end
        hold_v = rst && o_frame_valid && !i_frame_ready;
        hold_d = o_data_frame;
        hold_l = o_last;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        en            = 1'b0;
        i_code_rate   = 1'b0;
        i_bit         = 1'b0;
        i_bit_valid   = 1'b0;
        i_flush       = 1'b0;
        i_frame_ready = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 32'(o_data_frame), 32'h0);
        check("rst_valid", 32'(o_frame_valid), 32'd0);
        check("rst_last", 32'(o_last), 32'd0);
        check("rst_ready", 32'(o_bit_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;

        // Rate 1/2 basic frame and one-cycle latency.
        expect_frame(16'hE170, 1'b0);
        send_bits(16'b1011000, 7);
        check("lat_before", 32'(o_frame_valid), 32'd0);
        send_bit(1'b0);
        check("lat_after", 32'(o_frame_valid), 32'd1);
        check("thru_ready", 32'(o_bit_ready), 32'd1);
        wait_empty("t1_drain");

        // Rate 1/3, five slots, bit0 zero.
        i_code_rate = 1'b1;
        expect_frame(16'hF700, 1'b0);
        send_bits(16'b10000, 5);
        wait_empty("t2_drain");

        // Single bit then flush: tail plus pad in one last frame.
        i_code_rate = 1'b0;
        expect_frame(16'hEC00, 1'b1);
        send_bit(1'b1);
        pulse_flush();
        wait_valid("t3_valid");
        check("t3_last", 32'(o_last), 32'd1);
        check("t3_idle_ready", 32'(o_bit_ready), 32'd0);
        wait_empty("t3_drain");

        // Frame filled exactly by the second tail bit: no extra frame.
        expect_frame(16'hD4B0, 1'b1);
        send_bits(16'b110100, 6);
        pulse_flush();
        wait_empty("exact_drain");
        repeat (12) @(posedge clk);
        #1;
        check("exact_no_extra", 32'(o_frame_valid), 32'd0);

        // Tail overflows into a second frame which is padded.
        expect_frame(16'hE17E, 1'b0);
        expect_frame(16'hC000, 1'b1);
        send_bits(16'b1011001, 7);
        pulse_flush();
        wait_empty("ovf_drain");

        // Backpressure: two frames buffered, then input stalls.
        i_frame_ready = 1'b0;
        expect_frame(16'hD4BE, 1'b0);
        expect_frame(16'hF670, 1'b0);
        send_bits(16'b1101_0010_0111_0000, 16);
        check("bp_ready_low", 32'(o_bit_ready), 32'd0);
        check("bp_valid", 32'(o_frame_valid), 32'd1);
        check("bp_first_data", 32'(o_data_frame), 32'hD4BE);
        repeat (5) @(posedge clk);
        #1;
        check("bp_ready_still_low", 32'(o_bit_ready), 32'd0);
        i_frame_ready = 1'b1;
        wait_empty("bp_drain");
        check("bp_ready_back", 32'(o_bit_ready), 32'd1);

        // Rate change mid-frame is ignored until the next frame.
        i_code_rate = 1'b0;
        expect_frame(16'hE170, 1'b0);
        expect_frame(16'h1D3C, 1'b0);
        send_bits(16'b101, 3);
        i_code_rate = 1'b1;
        send_bits(16'b10000, 5);
        send_bits(16'b01100, 5);
        wait_empty("rc_drain");

        // Reset mid-frame discards everything; a fresh frame starts from s=00.
        i_code_rate   = 1'b0;
        i_frame_ready = 1'b0;
        send_bits(16'hFF, 8);
        check("mr_pre_valid", 32'(o_frame_valid), 32'd1);
        send_bits(16'hF, 4);
        rst = 1'b0;
        #1;
        check("mr_data", 32'(o_data_frame), 32'h0);
        check("mr_valid", 32'(o_frame_valid), 32'd0);
        check("mr_last", 32'(o_last), 32'd0);
        check("mr_ready", 32'(o_bit_ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst           = 1'b1;
        i_frame_ready = 1'b1;
        expect_frame(16'h3867, 1'b0);
        send_bits(16'b01011100, 8);
        wait_empty("mr_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
